// File: rtl/dispatch_stage.sv
// ID/EX dispatch register gating retire on per-unit issue handshakes.
// Optional skid entry under DISPATCH_SKID_EN registers ready_out toward decode.
module dispatch_stage #(
  parameter int DATA_W  = 256,
  parameter int N_UNITS = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [N_UNITS-1:0] unit_req_in,
  output logic               valid_out,
  input  logic               ready_in,
  output logic [DATA_W-1:0]  data_out,
  output logic [N_UNITS-1:0] unit_valid_out,
  input  logic [N_UNITS-1:0] unit_ready_in,
  output logic [1:0]         occupancy
);

  logic               acc;
  logic               ret;
  logic [N_UNITS-1:0] unit_left;

  // Units still owed an issue after this cycle's handshakes.
  assign unit_left = unit_valid_out & ~unit_ready_in;
  assign ret       = valid_out && ready_in && (unit_left == '0);
  assign acc       = valid_in && ready_out && !flush;

`ifdef DISPATCH_SKID_EN
  logic               skid_valid;
  logic [DATA_W-1:0]  skid_data;
  logic [N_UNITS-1:0] skid_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out      <= 1'b0;
      data_out       <= '0;
      unit_valid_out <= '0;
      skid_valid     <= 1'b0;
      skid_data      <= '0;
      skid_req       <= '0;
      ready_out      <= 1'b1;
    end else if (flush) begin
      valid_out      <= 1'b0;
      data_out       <= '0;
      unit_valid_out <= '0;
      skid_valid     <= 1'b0;
      skid_data      <= '0;
      skid_req       <= '0;
      ready_out      <= 1'b1;
    end else if (!valid_out) begin
      if (acc) begin
        valid_out      <= 1'b1;
        data_out       <= data_in;
        unit_valid_out <= unit_req_in;
      end
    end else if (ret) begin
      // Skid is drained first; acc cannot coincide with a full skid.
      if (skid_valid) begin
        data_out       <= skid_data;
        unit_valid_out <= skid_req;
        skid_valid     <= 1'b0;
        skid_data      <= '0;
        skid_req       <= '0;
        ready_out      <= 1'b1;
      end else if (acc) begin
        data_out       <= data_in;
        unit_valid_out <= unit_req_in;
      end else begin
        valid_out      <= 1'b0;
        data_out       <= '0;
        unit_valid_out <= '0;
      end
    end else begin
      unit_valid_out <= unit_left;
      if (acc) begin
        skid_valid <= 1'b1;
        skid_data  <= data_in;
        skid_req   <= unit_req_in;
        ready_out  <= 1'b0;
      end
    end
  end

  assign occupancy = {1'b0, valid_out} + {1'b0, skid_valid};
`else
  assign ready_out = !valid_out || ret;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out      <= 1'b0;
      data_out       <= '0;
      unit_valid_out <= '0;
    end else if (flush) begin
      valid_out      <= 1'b0;
      data_out       <= '0;
      unit_valid_out <= '0;
    end else if (acc) begin
      valid_out      <= 1'b1;
      data_out       <= data_in;
      unit_valid_out <= unit_req_in;
    end else if (ret) begin
      valid_out      <= 1'b0;
      data_out       <= '0;
      unit_valid_out <= '0;
    end else begin
      unit_valid_out <= unit_left;
    end
  end

  assign occupancy = {1'b0, valid_out};
`endif

endmodule

// File: tb/tb_dispatch_stage.sv
// Bench for dispatch_stage: directed steps then random traffic against a
// queue model of held instructions (head = output entry with its pending units).
`timescale 1ns/1ps
module tb_dispatch_stage;
  localparam int DATA_W  = 256;
  localparam int N_UNITS = 3;
`ifdef DISPATCH_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic               clk = 1'b0;
  logic               reset, flush, valid_in, ready_in;
  logic               ready_out, valid_out;
  logic [DATA_W-1:0]  data_in, data_out;
  logic [N_UNITS-1:0] unit_req_in, unit_valid_out, unit_ready_in;
  logic [1:0]         occupancy;
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [DATA_W-1:0]  data;
    logic [N_UNITS-1:0] mask;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  dispatch_stage #(.DATA_W(DATA_W), .N_UNITS(N_UNITS)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .valid_in(valid_in), .ready_out(ready_out), .data_in(data_in),
    .unit_req_in(unit_req_in), .valid_out(valid_out), .ready_in(ready_in),
    .data_out(data_out), .unit_valid_out(unit_valid_out),
    .unit_ready_in(unit_ready_in), .occupancy(occupancy)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_ret();
    return q.size() > 0 && ready_in && ((q[0].mask & ~unit_ready_in) == '0);
  endfunction

  function automatic logic m_ready();
    if (DEPTH == 2) return q.size() < 2;
    return q.size() == 0 || m_ret();
  endfunction

  task automatic check_outputs(input string tag);
    logic [DATA_W-1:0]  ed;
    logic [N_UNITS-1:0] eu;
    ed = '0;
    eu = '0;
    if (q.size() > 0) begin
      ed = q[0].data;
      eu = q[0].mask;
    end
    chk({tag, ".valid_out"}, DATA_W'(valid_out), DATA_W'(q.size() > 0));
    chk({tag, ".data_out"}, data_out, ed);
    chk({tag, ".unit_valid_out"}, DATA_W'(unit_valid_out), DATA_W'(eu));
    chk({tag, ".occupancy"}, DATA_W'(occupancy), DATA_W'(q.size()));
    chk({tag, ".ready_out"}, DATA_W'(ready_out), DATA_W'(m_ready()));
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [N_UNITS-1:0] req,
                       input logic rdy, input logic [N_UNITS-1:0] ur, input logic fl);
    valid_in = v; data_in = d; unit_req_in = req;
    ready_in = rdy; unit_ready_in = ur; flush = fl;
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic cycle(input string tag);
    logic r, a, fl;
    logic [N_UNITS-1:0] ur;
    ent_t e;
    #1;
    check_outputs(tag);
    r  = m_ret();
    a  = valid_in && m_ready() && !flush;
    fl = flush;
    ur = unit_ready_in;
    e.data = data_in;
    e.mask = unit_req_in;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (r) void'(q.pop_front());
      else if (q.size() > 0) q[0].mask = q[0].mask & ~ur;
      if (a) q.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    #1;
    check_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back flow, no units.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DATA_W'(i), '0, 1'b1, '0, 1'b0);
      cycle("b2b");
    end
    drive(1'b0, '0, '0, 1'b1, '0, 1'b0);
    cycle("b2b_tail");
    cycle("b2b_idle");

    // Unit gating: 101, unit 0 accepts at cycle 2, unit 2 at cycle 4.
    drive(1'b1, DATA_W'(32'h55), 3'b101, 1'b1, '0, 1'b0);
    cycle("gate_acc");
    for (int c = 1; c <= 5; c++) begin
      drive(1'b0, '0, '0, 1'b1, (c == 2) ? 3'b001 : (c == 4) ? 3'b100 : 3'b000, 1'b0);
      cycle("gate");
      if (c == 3) chk("gate.mid_mask", DATA_W'(unit_valid_out), DATA_W'(3'b100));
    end
    chk("gate.retired", DATA_W'(valid_out), '0);

    // Stall then release; order must be preserved.
    drive(1'b1, DATA_W'(32'h11), '0, 1'b0, '0, 1'b0);
    cycle("stall0");
    drive(1'b1, DATA_W'(32'h22), '0, 1'b0, '0, 1'b0);
    cycle("stall1");
    drive(1'b1, DATA_W'(32'h33), '0, 1'b0, '0, 1'b0);
    cycle("stall2");
    chk("stall.head", data_out, DATA_W'(32'h11));
    drive(1'b0, '0, '0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("release");

    // Flush with held instructions and pending unit bits.
    drive(1'b1, DATA_W'(32'h44), 3'b011, 1'b0, '0, 1'b0);
    cycle("fl_fill0");
    drive(1'b1, DATA_W'(32'h45), 3'b110, 1'b0, 3'b001, 1'b0);
    cycle("fl_fill1");
    drive(1'b1, DATA_W'(32'h46), 3'b111, 1'b1, 3'b111, 1'b1);
    cycle("flush");
    drive(1'b0, '0, '0, 1'b1, '0, 1'b0);
    chk("flush.occ", DATA_W'(occupancy), '0);
    cycle("post_flush");

    // Simultaneous retire + accept, no bubble.
    drive(1'b1, DATA_W'(32'h77), '0, 1'b1, '0, 1'b0);
    cycle("sim0");
    drive(1'b1, DATA_W'(32'hAA), '0, 1'b1, '0, 1'b0);
    cycle("sim1");
    drive(1'b0, '0, '0, 1'b1, '0, 1'b0);
    chk("sim.data", data_out, DATA_W'(32'hAA));
    cycle("sim2");

    // Asynchronous reset between edges while stalled.
    drive(1'b1, DATA_W'(32'h91), 3'b010, 1'b0, '0, 1'b0);
    cycle("rst_fill0");
    drive(1'b1, DATA_W'(32'h92), '0, 1'b0, '0, 1'b0);
    cycle("rst_fill1");
    #2;
    reset = 1'b1;
    q.delete();
    #1;
    check_outputs("async_reset");
    @(posedge clk);
    @(negedge clk);
    #1;
    check_outputs("reset_hold");
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);

    // Random traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0,
            {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            ($urandom_range(0, 2) == 0) ? N_UNITS'($urandom) : '0,
            $urandom_range(0, 9) < 7,
            N_UNITS'($urandom),
            $urandom_range(0, 29) == 0);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dispatch_stage.md
# dispatch_stage

Parametrised ID/EX dispatch register that holds one decoded instruction (an opaque payload) between decode and execute. It drives the in-order execute path and up to N side channels to multicycle functional units (MUL, DIV, FPU, …). An instruction may not leave the stage until every unit it requested has accepted it. The block adds a synchronous flush and an optional skid entry that removes the combinational ready path to decode.

## Interface
Parameters:
- DATA_W, 256, payload width in bits (PC, IR, immediate, operands, control fields packed by decode)
- N_UNITS, 3, number of functional-unit side channels

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous discard of all held instructions
- valid_in  in  1  decode has an instruction
- ready_out  out  1  stage accepts an instruction this cycle
- data_in  in  DATA_W  payload from decode
- unit_req_in  in  N_UNITS  one bit per unit the instruction must be issued to (any number, zero allowed)
- valid_out  out  1  output entry holds an instruction
- ready_in  in  1  execute path can take the output entry
- data_out  out  DATA_W  output entry payload
- unit_valid_out  out  N_UNITS  per-unit issue request for the output entry
- unit_ready_in  in  N_UNITS  per-unit accept
- occupancy  out  2  number of held instructions (0..1, or 0..2 with skid)

## Operation
- Accept: acc = valid_in && ready_out && !flush.
- Unit issue: unit_valid_out is loaded from unit_req_in when an instruction enters the output entry. Bit i clears on unit_valid_out[i] && unit_ready_in[i]. Bits clear independently of one another.
- Retire: ret = valid_out && ready_in && ((unit_valid_out & ~unit_ready_in) == 0). An entry whose units are still pending holds even if ready_in is 1. A unit handshake in the same cycle as ready_in counts toward retire.
- When the output entry retires with no replacement, valid_out, unit_valid_out and data_out are cleared to 0.
- Without skid: ready_out = !valid_out || ret (combinational). On acc the output entry is loaded; a simultaneous ret and acc replaces the entry in the same edge.
- With skid, acc while the output entry is occupied and not retiring writes the skid entry. On ret, the skid entry moves into the output entry and its stored unit_req is loaded into unit_valid_out. The skid entry and a new acc are never both pending in the same cycle, because ready_out is 0 whenever the skid entry is full.
- flush has priority over everything. Next edge: valid_out=0, unit_valid_out=0, skid cleared, data_out=0, occupancy=0. Any valid_in/ready_out handshake coinciding with flush is dropped. Unit handshakes coinciding with flush are ignored by this block; upstream flush logic owns their cancellation.
- occupancy = valid_out + skid_valid.

## Timing
- Reset values: valid_out=0, unit_valid_out=0, data_out=0, occupancy=0. ready_out is 1 combinationally without skid; with skid it is registered and resets to 1.
- Latency: acc at edge k gives valid_out=1 and data_out valid after edge k when the output entry is empty or retiring. Otherwise the instruction waits in skid until the first ret.
- Throughput: 1 instruction/cycle when ready_in=1 and no units are requested.
- unit_valid_out must not drop without a handshake, except on flush or reset.
- A reset asserted mid-operation clears everything immediately; no partial retire.

## Configuration
- DISPATCH_SKID_EN defined: 2-entry storage, ready_out = !skid_valid is a registered output, and occupancy ranges 0..2.
- DISPATCH_SKID_EN undefined: 1 entry, ready_out is combinational as above, and occupancy[1] is tied to 0.

## Test plan
- Back-to-back flow: 4 instructions (data 0x1..0x4, unit_req=0), ready_in=1 -> valid_out high 4 consecutive cycles, data_out 0x1..0x4, then 0 with valid_out=0.
- Unit gating: unit_req_in=3'b101, ready_in=1, unit_ready_in[0] at cycle 2, unit_ready_in[2] at cycle 4 -> unit_valid_out 101→100→000. Retire occurs at the cycle-4 edge, not earlier.
- Stall: ready_in=0 for 3 cycles with valid_in=1 -> without skid ready_out=0 after first accept and data_out holds. With DISPATCH_SKID_EN, a second instruction is accepted, occupancy=2, ready_out=0, and on release order is preserved (first, then second).
- Flush: occupancy=2 and pending unit bits, flush=1 with valid_in=1 -> next cycle occupancy=0, valid_out=0, unit_valid_out=0, and the incoming instruction is not present.
- Simultaneous retire+accept: valid_out=1, ready_in=1, valid_in=1 data 0xAA -> next cycle valid_out=1, data_out=0xAA, with no bubble.
- Async reset mid-stall: assert reset between edges while occupancy=2 -> all outputs reach reset values before the next edge.
